// File: rtl/maquina_verificadora_pkg.sv
// Shared definitions for the DigiLock sequence checker: FSM state encoding and default sizing.
package maquina_verificadora_pkg;

    typedef enum logic {
        VERIFICANDO = 1'b0,
        VALIDADO    = 1'b1
    } estado_t;

    localparam int N_COMPARACOES_DEF = 4;
    localparam int CNT_W_DEF         = 4;

endpackage : maquina_verificadora_pkg

// File: rtl/contador_consecutivo.sv
// Saturating count of consecutive correct digits; sync clear, async active-low reset.
// tc flags that the counter sits at N_COMPARACOES-1 (one more correct digit completes the code).
module contador_consecutivo
    import maquina_verificadora_pkg::*;
#(
    parameter int N_COMPARACOES = N_COMPARACOES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N_COMPARACOES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < ULTIMO)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == ULTIMO);

endmodule : contador_consecutivo

// File: rtl/maquina_verificadora.sv
// DigiLock code checker: raises saida after N_COMPARACOES consecutive correct digits.
// Build option MAQUINA_VERIFICADORA_PULSE_EN makes saida a one-cycle pulse instead of sticky.
module maquina_verificadora
    import maquina_verificadora_pkg::*;
#(
    parameter int N_COMPARACOES = N_COMPARACOES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic comparacao,
    output logic saida
);

    estado_t estado_q;
    estado_t estado_d;
    logic    saida_q;
    logic    saida_d;
    logic    inc;
    logic    clr;
    logic    tc;

    contador_consecutivo #(
        .N_COMPARACOES (N_COMPARACOES),
        .CNT_W         (CNT_W)
    ) u_contador (
        .clk (clk),
        .rst (rst),
        .inc (inc),
        .clr (clr),
        .tc  (tc)
    );

    always_comb begin
        estado_d = estado_q;
        inc      = 1'b0;
        clr      = 1'b0;
        case (estado_q)
            VERIFICANDO: begin
                if (comparacao) begin
                    if (tc) begin
                        estado_d = VALIDADO;
                        clr      = 1'b1;
                    end else begin
                        inc = 1'b1;
                    end
                end else begin
                    clr = 1'b1;
                end
            end
            VALIDADO: begin
                // comparacao is ignored here; the counter is held at zero for the next attempt
                clr = 1'b1;
`ifdef MAQUINA_VERIFICADORA_PULSE_EN
                estado_d = VERIFICANDO;
`else
                estado_d = VALIDADO;
`endif
            end
            default: begin
                estado_d = VERIFICANDO;
                clr      = 1'b1;
            end
        endcase
        saida_d = (estado_d == VALIDADO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q <= VERIFICANDO;
            saida_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            saida_q  <= saida_d;
        end
    end

    assign saida = saida_q;

endmodule : maquina_verificadora

// File: tb/tb_maquina_verificadora.sv
// Scoreboard bench for maquina_verificadora: directed plan then randomized traffic vs a run-length model.
module tb_maquina_verificadora;

    localparam int N = 4;

    logic clk;
    logic rst;
    logic comparacao;
    logic saida;

    typedef struct {
        bit exp;
        int ciclo;
    } esperado_t;

    esperado_t fila[$];
    int        vectors    = 0;
    int        miscompares = 0;
    int        ciclo_n    = 0;
    bit        fim        = 0;

    // reference model: length of the current run of correct digits and the "code accepted" flag
    int run   = 0;
    bit valid = 0;

    maquina_verificadora #(
        .N_COMPARACOES (N),
        .CNT_W         (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .comparacao (comparacao),
        .saida      (saida)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of stimulus");
        $fatal(1, "watchdog");
    end

    // One clock: apply the model for the edge using the inputs present at that edge,
    // then drive new inputs and queue the saida value expected at the following negedge.
    task automatic ciclo(input bit r, input bit c);
        esperado_t e;
        @(posedge clk);
        if (!rst) begin
            run   = 0;
            valid = 0;
        end else if (valid) begin
`ifdef MAQUINA_VERIFICADORA_PULSE_EN
            valid = 0;
            run   = 0;
`endif
        end else if (comparacao) begin
            run = run + 1;
            if (run == N) begin
                valid = 1;
                run   = 0;
            end
        end else begin
            run = 0;
        end
        #1;
        rst        = r;
        comparacao = c;
        if (!r) begin
            run   = 0;
            valid = 0;
        end
        ciclo_n++;
        e.exp   = valid;
        e.ciclo = ciclo_n;
        fila.push_back(e);
    endtask

    task automatic seq(input bit r, input int n, input bit c);
        for (int i = 0; i < n; i++) ciclo(r, c);
    endtask

    initial begin : monitor
        esperado_t e;
        forever begin
            @(negedge clk);
            if (fim) break;
            if (fila.size() > 0) begin
                e = fila.pop_front();
                vectors++;
                if (saida !== e.exp) begin
                    miscompares++;
                    $display("FAIL saida cycle %0d: got %b, expected %b", e.ciclo, saida, e.exp);
                end
            end
        end
    end

    initial begin : stimulus
        rst        = 1'b0;
        comparacao = 1'b0;

        // reset held while comparacao toggles, then release
        ciclo(0, 1); ciclo(0, 0); ciclo(0, 1);
        ciclo(1, 0);

        // broken sequence 1,0,1,1,1
        ciclo(1, 1); ciclo(1, 0); ciclo(1, 1); ciclo(1, 1); ciclo(1, 1);
        ciclo(1, 0);

        // valid code: 1,0 then five 1s, then 0s (sticky unless pulse build)
        ciclo(1, 1); ciclo(1, 0);
        seq(1, 5, 1);
        seq(1, 3, 0);

        // async reset while validated, then release together with comparacao=1
        ciclo(0, 0); ciclo(0, 1);
        seq(1, 4, 1);
        seq(1, 2, 0);

        // late fail: three 1s, 0, then four 1s
        ciclo(0, 0);
        seq(1, 3, 1); ciclo(1, 0);
        seq(1, 4, 1);
        seq(1, 2, 0);

        // long run of 1s: repeated pulses in pulse build, held high otherwise
        ciclo(0, 0);
        seq(1, 10, 1);
        ciclo(1, 0);

        // randomized traffic, mostly correct digits with occasional resets
        for (int i = 0; i < 2000; i++) begin
            bit r;
            bit c;
            r = ($urandom_range(0, 99) >= 3);
            c = ($urandom_range(0, 99) < 80);
            ciclo(r, c);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        fim = 1'b1;
        @(negedge clk);
        vectors++;
        if (fila.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", fila.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_maquina_verificadora
